spdif_frame_assembler: RTL

- Sits directly downstream of SPDIFdecoder, in the `clk` domain.
- Consumes decoded subframes (payload, preamble code, one-cycle strobe) and pairs left/right subframes into stereo frames.
- Checks parity and preamble sequence, and tracks the 192-frame block position.
- Captures the first 32 channel-status bits, and presents samples on a valid/ready stream to the audio sink.

---
 rtl/spdif_frame_assembler.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spdif_frame_assembler.sv
// spdif_frame_assembler
//   Pairs decoded S/PDIF subframes (left on B/M preamble, right on W) into
//   stereo frames. It checks parity and the preamble order, and it tracks the
//   position of each frame inside the 192-frame block. Completed pairs go to a
//   one-entry valid/ready output buffer.
//
// Optional feature: define SPDIF_CS_CAPTURE_EN to capture channel-status
// bits 0..31 into cs_word. Without it, cs_word and cs_valid are tied to 0.
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   sf_strobe        one-cycle strobe marking a valid subframe
//   sf_data[27:0]    {P, C, U, V, audio[23:0]}
//   sf_sync[1:0]     preamble: 0=B, 1=M, 2=W, 3=invalid
//   out_valid/ready  stereo pair handshake
//   out_left/right   sample MSBs, SAMPLE_W wide
//   out_vflag        {right V, left V}
//   out_block_start  the pair is frame 0 of a block
//   locked           LOCK_FRAMES error-free pairs seen since the last error
//   frame_idx        frame position 0..191
//   cs_word/cs_valid captured channel-status word and its update pulse
//   err_count        saturating error counter
//   overflow         sticky: a pair was dropped because the buffer was full
module spdif_frame_assembler #(
  parameter int SAMPLE_W    = 24,
  parameter int LOCK_FRAMES = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                sf_strobe,
  input  logic [27:0]         sf_data,
  input  logic [1:0]          sf_sync,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_left,
  output logic [SAMPLE_W-1:0] out_right,
  output logic [1:0]          out_vflag,
  output logic                out_block_start,
  output logic                locked,
  output logic [7:0]          frame_idx,
  output logic [31:0]         cs_word,
  output logic                cs_valid,
  output logic [7:0]          err_count,
  output logic                overflow
);
  localparam logic [1:0] SYNC_B = 2'd0;
  localparam logic [1:0] SYNC_M = 2'd1;
  localparam logic [1:0] SYNC_W = 2'd2;
  localparam logic [1:0] SYNC_X = 2'd3;
  localparam logic [7:0] LOCK_MAX   = 8'(LOCK_FRAMES);
  localparam logic [7:0] LAST_FRAME = 8'd191;

  typedef enum logic {HUNT = 1'b0, WAIT_R = 1'b1} state_e;
  state_e state_q, state_d;

  logic                parity_ok, is_b, is_m, is_w, seq_err;
  logic                err_evt, resync, acc_left, complete;

  logic [SAMPLE_W-1:0] lsamp_q, lsamp_d;
  logic                lv_q, lv_d, lb_q, lb_d;
  logic                block_sync_q, block_sync_d;
  logic [7:0]          pend_idx_q, pend_idx_d;
  logic [7:0]          good_cnt_q, good_cnt_d;
  logic [7:0]          frame_idx_q, frame_idx_d;
  logic [7:0]          err_q, err_d;
  logic                ovalid_q, ovalid_d, ovf_q, ovf_d, obs_q, obs_d;
  logic [SAMPLE_W-1:0] oleft_q, oleft_d, oright_q, oright_d;
  logic [1:0]          ovflag_q, ovflag_d;

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= HUNT;
    else       state_q <= state_d;
  end

  // FSM output decode: classify the current subframe
  always_comb begin
    parity_ok = ~(^sf_data);
    is_b      = (sf_sync == SYNC_B);
    is_m      = (sf_sync == SYNC_M);
    is_w      = (sf_sync == SYNC_W);
    seq_err   = 1'b0;
    if (sf_sync == SYNC_X)
      seq_err = 1'b1;
    else if (state_q == HUNT)
      seq_err = is_w
             || (block_sync_q && is_m && frame_idx_q == LAST_FRAME)
             || (block_sync_q && is_b && frame_idx_q != LAST_FRAME);
    else
      seq_err = is_b || is_m;
    err_evt  = sf_strobe && (!parity_ok || seq_err);
    // A clean B that breaks the sequence still starts a new block.
    resync   = err_evt && parity_ok && is_b;
    acc_left = resync
            || (sf_strobe && parity_ok && !seq_err && state_q == HUNT && (is_b || is_m));
    complete = sf_strobe && parity_ok && state_q == WAIT_R && is_w;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (acc_left)                 state_d = WAIT_R;
    else if (err_evt || complete) state_d = HUNT;
  end

  // Datapath next state
  always_comb begin
    lsamp_d      = lsamp_q;
    lv_d         = lv_q;
    lb_d         = lb_q;
    block_sync_d = block_sync_q;
    pend_idx_d   = pend_idx_q;
    good_cnt_d   = good_cnt_q;
    frame_idx_d  = frame_idx_q;
    err_d        = err_q;
    ovalid_d     = ovalid_q;
    ovf_d        = ovf_q;
    obs_d        = obs_q;
    oleft_d      = oleft_q;
    oright_d     = oright_q;
    ovflag_d     = ovflag_q;

    if (err_evt) begin
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
      good_cnt_d   = 8'd0;
      block_sync_d = 1'b0;
    end

    // Evaluated after the error clear so that a resync B can set block_sync again.
    if (acc_left) begin
      lsamp_d = sf_data[23 -: SAMPLE_W];
      lv_d    = sf_data[24];
      lb_d    = is_b;
      if (is_b) begin
        block_sync_d = 1'b1;
        pend_idx_d   = 8'd0;
      end else begin
        pend_idx_d = block_sync_q ? frame_idx_q + 8'd1 : 8'd0;
      end
    end

    if (ovalid_q && out_ready) ovalid_d = 1'b0;

    if (complete) begin
      frame_idx_d = pend_idx_q;
      if (good_cnt_q != LOCK_MAX) good_cnt_d = good_cnt_q + 8'd1;
      if (!ovalid_q || out_ready) begin
        ovalid_d = 1'b1;
        oleft_d  = lsamp_q;
        oright_d = sf_data[23 -: SAMPLE_W];
        ovflag_d = {sf_data[24], lv_q};
        obs_d    = block_sync_q && lb_q;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lsamp_q      <= '0;
      lv_q         <= 1'b0;
      lb_q         <= 1'b0;
      block_sync_q <= 1'b0;
      pend_idx_q   <= 8'd0;
      good_cnt_q   <= 8'd0;
      frame_idx_q  <= 8'd0;
      err_q        <= 8'd0;
      ovalid_q     <= 1'b0;
      ovf_q        <= 1'b0;
      obs_q        <= 1'b0;
      oleft_q      <= '0;
      oright_q     <= '0;
      ovflag_q     <= 2'b00;
    end else begin
      lsamp_q      <= lsamp_d;
      lv_q         <= lv_d;
      lb_q         <= lb_d;
      block_sync_q <= block_sync_d;
      pend_idx_q   <= pend_idx_d;
      good_cnt_q   <= good_cnt_d;
      frame_idx_q  <= frame_idx_d;
      err_q        <= err_d;
      ovalid_q     <= ovalid_d;
      ovf_q        <= ovf_d;
      obs_q        <= obs_d;
      oleft_q      <= oleft_d;
      oright_q     <= oright_d;
      ovflag_q     <= ovflag_d;
    end
  end

`ifdef SPDIF_CS_CAPTURE_EN
  logic [31:0] cs_shift_q, cs_shift_d, cs_word_q, cs_word_d;
  logic        lc_q, lc_d, cs_valid_q, cs_valid_d;

  // The C bit is held with the left subframe. It is committed only when the
  // pair completes, so that an aborted frame leaves no trace.
  always_comb begin
    cs_shift_d = cs_shift_q;
    cs_word_d  = cs_word_q;
    lc_d       = lc_q;
    cs_valid_d = 1'b0;
    if (err_evt)  cs_shift_d = '0;
    if (acc_left) lc_d = sf_data[26];
    if (complete && block_sync_q && pend_idx_q < 8'd32) begin
      cs_shift_d[pend_idx_q[4:0]] = lc_q;
      if (pend_idx_q == 8'd31) begin
        cs_word_d  = cs_shift_d;
        cs_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cs_shift_q <= '0;
      cs_word_q  <= '0;
      lc_q       <= 1'b0;
      cs_valid_q <= 1'b0;
    end else begin
      cs_shift_q <= cs_shift_d;
      cs_word_q  <= cs_word_d;
      lc_q       <= lc_d;
      cs_valid_q <= cs_valid_d;
    end
  end

  assign cs_word  = cs_word_q;
  assign cs_valid = cs_valid_q;
`else
  assign cs_word  = 32'd0;
  assign cs_valid = 1'b0;
`endif

  assign out_valid       = ovalid_q;
  assign out_left        = oleft_q;
  assign out_right       = oright_q;
  assign out_vflag       = ovflag_q;
  assign out_block_start = obs_q;
  assign locked          = (good_cnt_q == LOCK_MAX);
  assign frame_idx       = frame_idx_q;
  assign err_count       = err_q;
  assign overflow        = ovf_q;

endmodule
